rgb2gray_pipe: RTL and testbench

//  Parametrised, runtime-selectable RGB-to-grayscale converter with valid/ready

---
 rtl/rgb2gray_pipe.sv | 138 +++++++++++++
 tb/tb_rgb2gray_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_pipe.sv
// rtl/rgb2gray_pipe.sv - stallable 3-stage RGB-to-grayscale converter with frame sideband
//
// Purpose: weighted sum of R/G/B with a per-pixel selectable coefficient set,
// rounded, scaled back to DATA_W bits and saturated. A single global enable
// stalls the whole pipeline when the output is held.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   mode[1:0]               00 BT.601, 01 BT.709, 10 average, 11 green passthrough
//   din_valid / din_ready   input handshake
//   din_sof, din_eol        input frame sideband
//   r_data, g_data, b_data  input colour channels (DATA_W each)
//   dout_valid / dout_ready output handshake
//   dout_sof, dout_eol      output frame sideband, qualified by dout_valid
//   gray_data               gray result (DATA_W)

module rgb2gray_pipe #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              din_sof,
  input  logic              din_eol,
  input  logic [DATA_W-1:0] r_data,
  input  logic [DATA_W-1:0] g_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sof,
  output logic              dout_eol,
  output logic [DATA_W-1:0] gray_data
);

  localparam int PW = DATA_W + COEF_W;   // product width
  localparam int SW = PW + 2;            // sum width
  localparam int CW = COEF_W + 1;        // coefficient width, holds 256 << (COEF_W-8)
  localparam int SH = COEF_W - 8;

  localparam logic [SW-1:0]     RND     = SW'(1) << (COEF_W - 1);
  localparam logic [DATA_W-1:0] GRAY_MX = '1;

  // Base coefficients are at 8 fractional bits; scale them to COEF_W.
  function automatic logic [CW-1:0] scale(input logic [8:0] base);
    return CW'(base) << SH;
  endfunction

  logic            ce;
  logic [CW-1:0]   coef_r, coef_g, coef_b;
  logic [PW-1:0]   prod_r, prod_g, prod_b;

  logic            s1_valid, s1_sof, s1_eol;
  logic [PW-1:0]   s1_pr, s1_pg, s1_pb;
  logic            s2_valid, s2_sof, s2_eol;
  logic [SW-1:0]   s2_sum;
  logic [SW-1:0]   shifted;
  logic [DATA_W-1:0] gray_sat;

  // The whole pipeline moves together; a held output freezes every stage.
  assign ce        = ~dout_valid | dout_ready;
  assign din_ready = ce;

  // Mode is consumed at the input: the coefficients it selects are folded into
  // the stage-1 products, so each pixel carries its own mode's result forward
  // and a mode change only affects pixels accepted afterwards.
  // Passthrough uses (0, 1.0, 0), which after rounding and shifting yields g_data exactly.
  always_comb begin
    coef_r = scale(9'd77);
    coef_g = scale(9'd150);
    coef_b = scale(9'd29);
    case (mode)
      2'b01: begin
        coef_r = scale(9'd54);
        coef_g = scale(9'd183);
        coef_b = scale(9'd19);
      end
      2'b10: begin
        coef_r = scale(9'd85);
        coef_g = scale(9'd86);
        coef_b = scale(9'd85);
      end
      2'b11: begin
        coef_r = '0;
        coef_g = scale(9'd256);
        coef_b = '0;
      end
      default: ;
    endcase
  end

  assign prod_r = PW'(r_data) * PW'(coef_r);
  assign prod_g = PW'(g_data) * PW'(coef_g);
  assign prod_b = PW'(b_data) * PW'(coef_b);

  assign shifted  = s2_sum >> COEF_W;
  assign gray_sat = (shifted > SW'(GRAY_MX)) ? GRAY_MX : shifted[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eol     <= 1'b0;
      s1_pr      <= '0;
      s1_pg      <= '0;
      s1_pb      <= '0;
      s2_valid   <= 1'b0;
      s2_sof     <= 1'b0;
      s2_eol     <= 1'b0;
      s2_sum     <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eol   <= 1'b0;
      gray_data  <= '0;
    end else if (ce) begin
      // Stage 1: products
      s1_valid   <= din_valid;
      s1_sof     <= din_sof;
      s1_eol     <= din_eol;
      s1_pr      <= prod_r;
      s1_pg      <= prod_g;
      s1_pb      <= prod_b;
      // Stage 2: sum with round-half-up constant
      s2_valid   <= s1_valid;
      s2_sof     <= s1_sof;
      s2_eol     <= s1_eol;
      s2_sum     <= SW'(s1_pr) + SW'(s1_pg) + SW'(s1_pb) + RND;
      // Stage 3: scale back and saturate
      dout_valid <= s2_valid;
      dout_sof   <= s2_sof;
      dout_eol   <= s2_eol;
      gray_data  <= gray_sat;
    end
  end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb/tb_rgb2gray_pipe.sv - directed self-checking bench for rgb2gray_pipe

module tb_rgb2gray_pipe;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       din_valid, din_ready, din_sof, din_eol;
  logic [7:0] r_data, g_data, b_data;
  logic       dout_valid, dout_ready, dout_sof, dout_eol;
  logic [7:0] gray_data;

  logic       w_valid, w_ready, w_dout_valid, w_dout_sof, w_dout_eol;
  logic [1:0] w_mode;
  logic [9:0] w_r, w_g, w_b, w_gray;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_gray[$];
  logic       q_sof[$];
  logic       q_eol[$];
  int         q_cyc[$];

  rgb2gray_pipe #(.DATA_W(8), .COEF_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_sof(din_sof), .din_eol(din_eol),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sof(dout_sof), .dout_eol(dout_eol), .gray_data(gray_data)
  );

  rgb2gray_pipe #(.DATA_W(10), .COEF_W(12)) dut_w (
    .clk(clk), .rst_n(rst_n), .mode(w_mode),
    .din_valid(w_valid), .din_ready(w_ready),
    .din_sof(1'b0), .din_eol(1'b0),
    .r_data(w_r), .g_data(w_g), .b_data(w_b),
    .dout_valid(w_dout_valid), .dout_ready(1'b1),
    .dout_sof(w_dout_sof), .dout_eol(w_dout_eol), .gray_data(w_gray)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      q_gray.push_back(gray_data);
      q_sof.push_back(dout_sof);
      q_eol.push_back(dout_eol);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_gray.delete();
    q_sof.delete();
    q_eol.delete();
    q_cyc.delete();
  endtask

  task automatic set_px(input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic sof, input logic eol);
    mode      = m;
    r_data    = r;
    g_data    = g;
    b_data    = b;
    din_sof   = sof;
    din_eol   = eol;
    din_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (dout_valid !== 1'b0 || gray_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: dout_valid=%b gray=%0d want 0/0", dout_valid, gray_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready: got %b want 1", din_ready);
    end
    checks++;
    if (dout_valid !== 1'b0 || dout_sof !== 1'b0 || dout_eol !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b sof=%b eol=%b want 0/0/0", dout_valid, dout_sof, dout_eol);
    end
    checks++;
    if (gray_data !== 8'd0 || w_dout_valid !== 1'b0 || w_gray !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: gray=%0d w_valid=%b w_gray=%0d want 0/0/0", gray_data, w_dout_valid, w_gray);
    end
  endtask

  // Feed four pixels back to back and check values and 3-cycle latency.
  task automatic run_four(input string name, input logic [1:0] m[4], input logic [7:0] r[4],
                          input logic [7:0] g[4], input logic [7:0] b[4], input logic [7:0] exp_g[4]);
    int c0;
    clear_q();
    dout_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      set_px(m[i], r[i], g[i], b[i], 1'b0, 1'b0);
      tick();
    end
    din_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (q_gray.size() != 4) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels want 4", name, q_gray.size());
    end
    for (int i = 0; i < 4 && i < q_gray.size(); i++) begin
      checks++;
      if (q_gray[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL %s_gray[%0d]: got %0d want %0d", name, i, q_gray[i], exp_g[i]);
      end
      checks++;
      if (q_cyc[i] != c0 + i + 3) begin
        errors++;
        $display("FAIL %s_latency[%0d]: out cycle %0d want %0d", name, i, q_cyc[i], c0 + i + 3);
      end
    end
  endtask

  task automatic test_bt601();
    logic [1:0] m[4]  = '{2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] r[4]  = '{8'd255, 8'd0, 8'd255, 8'd128};
    logic [7:0] g[4]  = '{8'd255, 8'd0, 8'd0,   8'd128};
    logic [7:0] b[4]  = '{8'd255, 8'd0, 8'd0,   8'd128};
    logic [7:0] e[4]  = '{8'd255, 8'd0, 8'd77,  8'd128};
    run_four("bt601", m, r, g, b, e);
  endtask

  // Mode changes on every pixel: each result must follow its own mode.
  task automatic test_modes();
    logic [1:0] m[4]  = '{2'd1,   2'd2,   2'd3,   2'd3};
    logic [7:0] r[4]  = '{8'd255, 8'd255, 8'd255, 8'd0};
    logic [7:0] g[4]  = '{8'd0,   8'd0,   8'd0,   8'd200};
    logic [7:0] b[4]  = '{8'd0,   8'd0,   8'd0,   8'd0};
    logic [7:0] e[4]  = '{8'd54,  8'd85,  8'd0,   8'd200};
    run_four("modes", m, r, g, b, e);
  endtask

  task automatic test_stall();
    int k;
    int c;
    int stalls;
    logic prev_stall;
    logic [7:0] pg;
    logic ps, pe;
    logic accepted;
    logic [7:0] v;
    clear_q();
    k = 0;
    c = 0;
    stalls = 0;
    prev_stall = 1'b0;
    pg = '0;
    ps = 1'b0;
    pe = 1'b0;
    while (k < 8 && c < 100) begin
      dout_ready = !(c >= 4 && c <= 6);
      v = 8'(10 * k + 5);
      set_px(2'd0, v, v, v, k == 0, k == 7);
      #1;
      if (prev_stall) begin
        checks++;
        if (dout_valid !== 1'b1 || gray_data !== pg || dout_sof !== ps || dout_eol !== pe) begin
          errors++;
          $display("FAIL stall_hold c=%0d: valid=%b gray=%0d sof=%b eol=%b want 1/%0d/%b/%b",
                   c, dout_valid, gray_data, dout_sof, dout_eol, pg, ps, pe);
        end
      end
      if (dout_valid && !dout_ready) begin
        stalls++;
        checks++;
        if (din_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_din_ready c=%0d: got %b want 0", c, din_ready);
        end
        prev_stall = 1'b1;
        pg = gray_data;
        ps = dout_sof;
        pe = dout_eol;
      end else begin
        prev_stall = 1'b0;
      end
      accepted = din_valid && din_ready;
      tick();
      if (accepted) k++;
      c++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL stall_timeout: accepted %0d pixels want 8", k);
    end
    repeat (8) tick();
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL stall_cycles: saw %0d stalled cycles want 3", stalls);
    end
    checks++;
    if (q_gray.size() != 8) begin
      errors++;
      $display("FAIL stall_count: got %0d pixels want 8", q_gray.size());
    end
    for (int i = 0; i < 8 && i < q_gray.size(); i++) begin
      checks++;
      if (q_gray[i] !== 8'(10 * i + 5) || q_sof[i] !== (i == 0) || q_eol[i] !== (i == 7)) begin
        errors++;
        $display("FAIL stall_px[%0d]: gray=%0d sof=%b eol=%b want %0d/%b/%b",
                 i, q_gray[i], q_sof[i], q_eol[i], 10 * i + 5, i == 0, i == 7);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int c1;
    clear_q();
    dout_ready = 1'b1;
    set_px(2'd0, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0);
    tick();
    set_px(2'd0, 8'd50, 8'd50, 8'd50, 1'b0, 1'b0);
    tick();
    din_valid = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || gray_data !== 8'd100) begin
      errors++;
      $display("FAIL midrst_before: valid=%b gray=%0d want 1/100", dout_valid, gray_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || gray_data !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b gray=%0d want 0/0", dout_valid, gray_data);
    end
    tick();
    rst_n = 1'b1;
    clear_q();
    tick();
    c1 = cyc;
    set_px(2'd0, 8'd60, 8'd60, 8'd60, 1'b0, 1'b0);
    tick();
    din_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (q_gray.size() != 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d pixels want 1", q_gray.size());
    end else begin
      checks++;
      if (q_gray[0] !== 8'd60 || q_cyc[0] != c1 + 3) begin
        errors++;
        $display("FAIL midrst_resume: gray=%0d cycle=%0d want 60/%0d", q_gray[0], q_cyc[0], c1 + 3);
      end
    end
  endtask

  // DATA_W=10, COEF_W=12: full-scale white, red-only and green passthrough.
  task automatic test_wide();
    w_mode  = 2'd0;
    w_r     = 10'd1023;
    w_g     = 10'd1023;
    w_b     = 10'd1023;
    w_valid = 1'b1;
    tick();
    w_g = 10'd0;
    w_b = 10'd0;
    tick();
    w_mode = 2'd3;
    w_r    = 10'd5;
    w_g    = 10'd1023;
    w_b    = 10'd7;
    tick();
    w_valid = 1'b0;
    checks++;
    if (w_dout_valid !== 1'b1 || w_gray !== 10'd1023) begin
      errors++;
      $display("FAIL wide_white: valid=%b gray=%0d want 1/1023", w_dout_valid, w_gray);
    end
    tick();
    checks++;
    if (w_dout_valid !== 1'b1 || w_gray !== 10'd308) begin
      errors++;
      $display("FAIL wide_red: valid=%b gray=%0d want 1/308", w_dout_valid, w_gray);
    end
    tick();
    checks++;
    if (w_dout_valid !== 1'b1 || w_gray !== 10'd1023) begin
      errors++;
      $display("FAIL wide_green: valid=%b gray=%0d want 1/1023", w_dout_valid, w_gray);
    end
    tick();
    checks++;
    if (w_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL wide_drain: valid=%b want 0", w_dout_valid);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = 2'd0;
    din_valid  = 1'b0;
    din_sof    = 1'b0;
    din_eol    = 1'b0;
    r_data     = '0;
    g_data     = '0;
    b_data     = '0;
    dout_ready = 1'b1;
    w_mode     = 2'd0;
    w_valid    = 1'b0;
    w_r        = '0;
    w_g        = '0;
    w_b        = '0;
    test_reset();
    test_bt601();
    test_modes();
    test_stall();
    test_reset_midflight();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
